// File: rtl/peaks_pkg.sv
// Shared definitions for the peak-frame capture path: register map, word/frame
// layouts and the peak packing helper.
package peaks_pkg;

    // Build configuration of the peak detector feeding this path.
    localparam int PEAKS_N = 6;
    localparam int FREQ_W  = 7;
    localparam int AMPL_W  = 18;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_SEQ    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [7:0] DROP_SAT = 8'd255;

    typedef struct packed {
        logic [7:0]  freq;
        logic [23:0] ampl;
    } peak_word_t;

    typedef struct packed {
        peak_word_t [PEAKS_N-1:0] words;
        logic [15:0]              seq;
    } frame_t;

    // Caller supplies freq zero-extended and amplitude sign-extended.
    function automatic peak_word_t pack_peak(input logic [7:0] freq,
                                             input logic signed [23:0] ampl);
        peak_word_t w;
        w.freq = freq;
        w.ampl = ampl;
        return w;
    endfunction

endpackage

// File: rtl/peak_frame_ram.sv
// Frame storage: one lane RAM per peak slot so a whole frame is written in one
// cycle, with an asynchronous read addressed by {frame slot, word index}.
module peak_frame_ram
    import peaks_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int WPW   = (PEAKS_N > 1) ? $clog2(PEAKS_N) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  frame_t           wdata_i,
    input  logic [PW-1:0]    raddr_i,
    input  logic [WPW-1:0]   word_i,
    output peak_word_t       rword_o,
    output logic [15:0]      rseq_o
);

    peak_word_t  lane_rd [PEAKS_N];
    logic [15:0] seq_mem [DEPTH];

    for (genvar gi = 0; gi < PEAKS_N; gi++) begin : g_lane
        peak_word_t lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we_i) begin
                lane_mem[waddr_i] <= wdata_i.words[gi];
            end
        end

        assign lane_rd[gi] = lane_mem[raddr_i];
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            seq_mem[waddr_i] <= wdata_i.seq;
        end
    end

    assign rseq_o = seq_mem[raddr_i];

    always_comb begin
        rword_o = '0;
        for (int i = 0; i < PEAKS_N; i++) begin
            if (word_i == WPW'(i)) begin
                rword_o = lane_rd[i];
            end
        end
    end

endmodule

// File: rtl/peak_frame_reader.sv
// Captures one peak list per valid_in pulse into a DEPTH-frame FIFO and serves
// it word by word over an Avalon-MM slave with status, sequence and control.
module peak_frame_reader
    import peaks_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PEAKS      = PEAKS_N,
    parameter int FREQ_WIDTH = FREQ_W,
    parameter int AMPL_WIDTH = AMPL_W
) (
    input  logic                                CLOCK_50,
    input  logic                                reset,
    input  logic                                valid_in,
    input  logic [PEAKS-1:0][AMPL_WIDTH-1:0]    amplitudes_in,
    input  logic [PEAKS-1:0][FREQ_WIDTH-1:0]    freqs_in,
    input  logic                                chipselect,
    input  logic                                read,
    input  logic                                write,
    input  logic [1:0]                          address,
    input  logic [31:0]                         writedata,
    output logic [31:0]                         readdata,
    output logic                                irq
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WPW = (PEAKS > 1) ? $clog2(PEAKS) : 1;

    logic            v1_q, v2_q;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WPW-1:0]  wptr_q, wptr_d;
    logic [15:0]     seq_q, seq_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_q, drop_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            irq_q;

    logic            capture, rd_en, wr_en, empty, full;
    logic            flush, clear, data_rd, pop, accept, drop;
    frame_t          cap_frame;
    peak_word_t      rd_word;
    logic [15:0]     rd_seq;
    logic            unused_wdata;

    assign unused_wdata = ^writedata[31:2];

    // Second-stage detect gives the peak detector one cycle to settle.
    assign capture = v1_q & ~v2_q;
    assign rd_en   = chipselect & read;
    assign wr_en   = chipselect & write;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign flush   = wr_en && (address == ADDR_CTRL) && writedata[1];
    assign clear   = wr_en && (address == ADDR_CTRL) && writedata[0];
    assign data_rd = rd_en && (address == ADDR_DATA) && !empty;
    assign pop     = data_rd && (wptr_q == WPW'(PEAKS - 1));
    // A same-cycle final-word pop frees a slot, so a full FIFO still accepts.
    assign accept  = capture && !flush && (!full || pop);
    assign drop    = capture && !flush && full && !pop;

    always_comb begin
        cap_frame     = '0;
        cap_frame.seq = seq_q;
        for (int i = 0; i < PEAKS; i++) begin
            cap_frame.words[i] = pack_peak(8'(freqs_in[i]),
                                           24'($signed(amplitudes_in[i])));
        end
    end

    peak_frame_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (CLOCK_50),
        .we_i    (accept),
        .waddr_i (tail_q),
        .wdata_i (cap_frame),
        .raddr_i (head_q),
        .word_i  (wptr_q),
        .rword_o (rd_word),
        .rseq_o  (rd_seq)
    );

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (address)
                ADDR_STATUS: rdata_d = {ovf_q, 7'd0, drop_q, 16'(count_q)};
                ADDR_DATA:   rdata_d = empty ? 32'd0 : rd_word;
                ADDR_SEQ:    rdata_d = empty ? 32'd0 : {16'd0, rd_seq};
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wptr_d  = wptr_q;
        seq_d   = seq_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (data_rd) begin
            if (pop) begin
                wptr_d = '0;
                head_d = head_q + PW'(1);
            end else begin
                wptr_d = wptr_q + WPW'(1);
            end
        end

        if (accept) begin
            tail_d = tail_q + PW'(1);
        end

        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CW'(1);
        end

        if (capture) begin
            seq_d = seq_q + 16'd1;
        end

        if (clear) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_d != DROP_SAT) begin
                drop_d = drop_d + 8'd1;
            end
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            wptr_d  = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wptr_q  <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            v1_q    <= valid_in;
            v2_q    <= v1_q;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            irq_q   <= (count_d != '0);
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
